// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: shares one single-clock FIFO between NUM_REQ producers.
// The write side is a round-robin push arbiter. The read side issues pops
// against the FIFO's registered (1-cycle latency) data_out. It also lands
// each popped word in a 2-entry in-order buffer that drives a valid/ready
// output stream.
module fifo_share_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  // producer side
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ID_WIDTH-1:0]           grant_id,
  // shared FIFO write port
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  // shared FIFO read port
  output logic                          fifo_pop,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  // output stream
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [ID_WIDTH-1:0]   r_rr_ptr;     // highest-priority requester
  logic [1:0]            r_occ;        // output buffer occupancy, 0..2
  logic                  r_inflight;   // a pop was issued last cycle
  logic [DATA_WIDTH-1:0] r_buf_head;   // oldest buffered word
  logic [DATA_WIDTH-1:0] r_buf_tail;   // second buffered word

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic                  w_any;        // at least one requester is valid
  logic [ID_WIDTH-1:0]   w_grant_id;   // winner of the round-robin search
  logic [ID_WIDTH-1:0]   w_cand;       // candidate index during the search
  logic                  w_push_ok;    // push handshake this cycle
  logic                  w_fire;       // output stream handshake
  logic [2:0]            w_level;      // occ + inflight - fire
  logic [1:0]            w_after_fire; // occupancy left once the head drains
  logic [DATA_WIDTH-1:0] w_head_next;
  logic [DATA_WIDTH-1:0] w_tail_next;

  // Round-robin search starting at r_rr_ptr and wrapping modulo NUM_REQ
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_any      = 1'b0;
    w_grant_id = '0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any      = 1'b1;
        w_grant_id = w_cand;
      end
    end
  end

  // A push happens only when someone is granted and the FIFO has room.
  // Nothing is pushed while reset is held.
  assign w_push_ok = w_any && !fifo_full && !reset;
  assign fifo_push = w_push_ok;
  assign grant_id  = w_grant_id;

  // Steer the winner's ready and payload; ready stays one-hot or zero
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_WIDTH'(i)) begin
        req_ready[i] = w_push_ok;
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf_head;
  assign w_fire  = m_valid && m_ready;

  // The occupancy after this edge counts the word in flight, because it
  // lands in the buffer at this edge. A pop is only issued when that word
  // is guaranteed a free slot next cycle, so the buffer never exceeds two.
  assign w_level      = 3'(r_occ) + 3'(r_inflight) - 3'(w_fire);
  assign fifo_pop     = !reset && !fifo_empty && (w_level < 3'd2);
  assign w_after_fire = r_occ - 2'(w_fire);

  // Next buffer contents: drain the head, then append an arriving word
  always_comb begin
    w_head_next = r_buf_head;
    w_tail_next = r_buf_tail;
    if (w_fire) begin
      w_head_next = r_buf_tail;
    end
    if (r_inflight) begin
      if (w_after_fire == 2'd0) begin
        w_head_next = fifo_data_out;
      end else begin
        w_tail_next = fifo_data_out;
      end
    end
  end

  // Round-robin pointer: advance past the winner only on a real push
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples values from before the edge regardless of order.
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_push_ok) begin
      if (int'(w_grant_id) == NUM_REQ - 1) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_grant_id + 1'b1;
      end
    end
  end

  // Output buffer, occupancy and in-flight tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two buffer entries are reset along with the control state.
      // m_data is driven straight from the head entry, so it reads 0 after
      // reset instead of stale data.
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf_head <= '0;
      r_buf_tail <= '0;
    end else begin
      r_occ      <= w_level[1:0];
      r_inflight <= fifo_pop;
      r_buf_head <= w_head_next;
      r_buf_tail <= w_tail_next;
    end
  end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb_fifo_share_ctrl: directed bench for fifo_share_ctrl. It uses a 16-deep
// behavioural FIFO with a registered read and per-producer word generators.
// A scoreboard queue is filled at each push handshake and drained at each
// output handshake.
module tb_fifo_share_ctrl;

  localparam int NR    = 4;
  localparam int DW    = 64;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [IW-1:0]     grant_id;
  logic              fifo_push;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_data_out;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_ready = 1'b0;

  fifo_share_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id),
    .fifo_push(fifo_push), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .fifo_pop(fifo_pop), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Behavioural shared FIFO: registered read, one cycle of read latency
  logic [DW-1:0] f_mem [DEPTH];
  int f_cnt = 0;
  int f_wr  = 0;
  int f_rd  = 0;
  assign fifo_full  = (f_cnt == DEPTH);
  assign fifo_empty = (f_cnt == 0);

  always @(posedge clk) begin
    if (reset) begin
      f_cnt <= 0; f_wr <= 0; f_rd <= 0; fifo_data_out <= '0;
    end else begin
      if (fifo_push && !fifo_full) begin
        f_mem[f_wr] <= fifo_data_in;
        f_wr <= (f_wr + 1) % DEPTH;
      end
      if (fifo_pop && !fifo_empty) begin
        fifo_data_out <= f_mem[f_rd];
        f_rd <= (f_rd + 1) % DEPTH;
      end
      f_cnt <= f_cnt + int'(fifo_push && !fifo_full) - int'(fifo_pop && !fifo_empty);
    end
  end

  // Check bookkeeping
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer generators and scoreboard
  int          p_left [NR];
  int          p_seq  [NR];
  logic [63:0] p_base [NR];
  logic [63:0] exp_q [$];
  int          hs_id = -1;
  int          hs_count = 0;
  int          n_out = 0;

  function automatic logic [63:0] p_word(input int i);
    return p_base[i] + 64'(p_seq[i]);
  endfunction

  function automatic bit any_left();
    for (int i = 0; i < NR; i++) if (p_left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (p_left[i] > 0);
      req_data[i*DW +: DW] = p_word(i);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then drive the next cycle
  task automatic step();
    @(negedge clk);
    hs_id = -1;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        hs_id = i;
        hs_count++;
        exp_q.push_back(p_word(i));
        check("push_data", fifo_data_in, p_word(i));
        p_seq[i]++;
        p_left[i]--;
      end
    end
    @(posedge clk);
    #1 drive();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic drain(input int max_cycles);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || any_left()) && t < max_cycles) begin
      step();
      t++;
    end
    check("drain_in_budget", t < max_cycles, 1);
  endtask

  // Output monitor: reference occupancy model, pop rule, hold and ordering
  int          b_occ = 0;
  logic        b_infl = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    logic fire;
    logic epop;
    if (reset) begin
      b_occ = 0; b_infl = 1'b0; prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      fire = m_valid && m_ready;
      check("m_valid_vs_occ", m_valid, b_occ != 0);
      epop = !fifo_empty && ((b_occ + int'(b_infl) - int'(fire)) < 2);
      check("pop_rule", fifo_pop, epop);
      check("push_vs_full", fifo_push && fifo_full, 0);
      check("ready_onehot0", $onehot0(req_ready), 1);
      if (prev_stall) check("stall_hold_data", m_data, prev_data);
      if (fire) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("m_data_order", m_data, exp_q.pop_front());
        n_out++;
      end
      b_occ  = b_occ + int'(b_infl) - int'(fire);
      b_infl = epop;
      check("occ_bound", b_occ <= 2, 1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int exp_rr [4];
    for (int i = 0; i < NR; i++) begin
      p_left[i] = 0; p_seq[i] = 0; p_base[i] = 64'(i + 1) << 56;
    end

    // ---- reset state, with all requesters valid ----
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b1111;
    #1;
    check("rst_m_valid",   m_valid,   0);
    check("rst_m_data",    m_data,    0);
    check("rst_fifo_pop",  fifo_pop,  0);
    check("rst_fifo_push", fifo_push, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    #1 check("idle_grant_id", grant_id, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // ---- single word latency ----
    m_ready = 1'b1;
    p_base[0] = 64'hA5; p_seq[0] = 0; p_left[0] = 1;
    step();                                   // cycle 0
    check("sw_push",      fifo_push,    1);
    check("sw_ready",     req_ready,    4'b0001);
    check("sw_grant",     grant_id,     0);
    check("sw_data_in",   fifo_data_in, 64'hA5);
    step();                                   // cycle 1
    check("sw_hs_id",     hs_id,        0);
    check("sw_pop_c1",    fifo_pop,     1);
    check("sw_no_push_c1", fifo_push,   0);
    step();                                   // cycle 2
    check("sw_valid_c2",  m_valid,      0);
    step();                                   // cycle 3
    check("sw_valid_c3",  m_valid,      1);
    check("sw_data_c3",   m_data,       64'hA5);
    step();                                   // cycle 4
    check("sw_valid_c4",  m_valid,      0);

    // ---- round robin, all four valid, full throughput ----
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      p_base[i] = 64'(i + 1) << 60; p_seq[i] = 0; p_left[i] = 2;
    end
    n0 = n_out;
    step();                                   // cycle 0
    for (int k = 0; k < 8; k++) begin
      step();                                 // now in cycle k+1
      check("rr_grant_order", hs_id, k % 4);
      if (k + 1 >= 3) check("rr_stream_valid", m_valid, 1);
    end
    step(); check("rr_valid_c9",  m_valid, 1);
    step(); check("rr_valid_c10", m_valid, 1);
    step(); check("rr_valid_c11", m_valid, 0);
    check("rr_out_count", n_out - n0, 8);
    check("rr_idle_grant", grant_id, 0);

    // ---- full stall, single streaming producer ----
    apply_reset();
    m_ready = 1'b0;
    p_base[2] = 64'hC000_0000_0000_0000; p_seq[2] = 0; p_left[2] = 30;
    n0 = hs_count;
    repeat (30) step();
    check("full_accepted", hs_count - n0, 18);
    check("full_ready",    req_ready,     0);
    check("full_no_push",  fifo_push,     0);
    check("full_grant",    grant_id,      2);
    check("full_m_valid",  m_valid,       1);
    m_ready = 1'b1;
    drain(300);
    check("full_total",    hs_count - n0, 30);

    // ---- backpressure with the buffer full ----
    m_ready = 1'b0;
    p_base[1] = 64'hB000_0000_0000_0000; p_seq[1] = 0; p_left[1] = 8;
    repeat (10) step();
    check("bp_m_valid", m_valid,  1);
    check("bp_no_pop",  fifo_pop, 0);
    for (int k = 0; k < 8; k++) begin
      m_ready = (k % 2 == 0);
      #1 check("bp_pop_toggle", fifo_pop, m_ready);
      step();
    end
    m_ready = 1'b1;
    drain(200);

    // ---- skip-idle fairness from rr_ptr = 1 ----
    apply_reset();
    m_ready = 1'b1;
    p_base[0] = 64'hD000_0000_0000_0000; p_seq[0] = 0; p_left[0] = 1;
    step();
    step();
    check("fair_setup_hs", hs_id, 0);
    p_left[0] = 2;
    p_base[2] = 64'hE000_0000_0000_0000; p_seq[2] = 0; p_left[2] = 2;
    step();
    exp_rr[0] = 2; exp_rr[1] = 0; exp_rr[2] = 2; exp_rr[3] = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fair_grant_order", hs_id, exp_rr[k]);
    end
    drain(100);

    // ---- reset mid-stream with the buffer full ----
    m_ready = 1'b0;
    p_base[3] = 64'hF000_0000_0000_0000; p_seq[3] = 0; p_left[3] = 12;
    repeat (7) step();
    check("mid_pre_valid", m_valid, 1);
    reset = 1'b1;
    p_base[0] = 64'h9000_0000_0000_0000; p_seq[0] = 0; p_left[0] = 2;
    step();
    check("mid_m_valid",   m_valid,   0);
    check("mid_fifo_pop",  fifo_pop,  0);
    check("mid_req_ready", req_ready, 0);
    check("mid_fifo_push", fifo_push, 0);
    reset = 1'b0;
    #1 check("mid_first_ready", req_ready, 4'b0001);
    step();
    check("mid_first_winner", hs_id, 0);
    m_ready = 1'b1;
    drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
